ysyx_25020047_lsu_pipe: RTL and testbench
=========================================

# ysyx_25020047_lsu_pipe

Handshaked load/store unit between EXU and WBU. It is the parametrised replacement for the combinational DPI-backed LSU. Each accepted request becomes at most one transaction on a latency-tolerant memory bus. Stores get byte strobes; loads are extracted and sign/zero-extended per funct3. Misalignment, illegal ops, bus errors and response timeouts are reported as error codes, never as silent writes.

## Interface
- XLEN, 32: datapath and bus data width; 32 or 64 only.
- TIMEOUT, 1024: max cycles in REQ+WAIT before a timeout fault; 0 disables.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  high only in IDLE
- req_op  in  4  {is_store, funct3}
- req_addr  in  32  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- resp_valid  out  1  result valid to WBU
- resp_ready  in  1  WBU accepts result
- resp_data  out  XLEN  extended load data; 0 for stores and faults
- resp_err  out  2  00 OK, 01 addr/op fault, 10 bus error, 11 timeout
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  req_addr with low log2(XLEN/8) bits cleared
- mem_wdata  out  XLEN  store data shifted to byte lane
- mem_wstrb  out  XLEN/8  byte strobes; all 0 for reads
- mem_rsp_valid  in  1  bus response valid, always accepted
- mem_rsp_data  in  XLEN  full aligned read word
- mem_rsp_err  in  1  bus access error

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset → IDLE.
- IDLE: on req_valid && req_ready, latch op, addr, wdata and decode.
- Legal ops: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores 000 SB, 001 SH, 010 SW.
- XLEN=64 adds load 011 LD, 110 LWU and store 011 SD. All other encodings are illegal.
- Size is 1/2/4/8 bytes. The address is misaligned if addr mod size ≠ 0.
- Illegal or misaligned: IDLE→RESP with err=01. No bus transaction; mem_wstrb is never asserted.
- Legal: IDLE→REQ.
- Byte offset o = addr mod (XLEN/8).
- mem_wdata = wdata << 8·o.
- mem_wstrb = ((1<<size)−1) << o. Examples: SH at o=2 → 4'b1100; SB at o=3 → 4'b1000.
- REQ: mem_req_valid=1 with payload stable until mem_req_ready, then →WAIT.
- WAIT: on mem_rsp_valid →RESP.
- If mem_rsp_err: err=10, data 0.
- Else, for loads: data = (mem_rsp_data >> 8·o), truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD) to XLEN.
- For stores: data 0.
- RESP: resp_valid=1 holding data and err until resp_ready, then →IDLE.
- Timeout counter: cleared on request accept, increments every cycle in REQ or WAIT.
- When TIMEOUT≠0 and count reaches TIMEOUT−1, the next edge forces →RESP with err=11 and deasserts mem_req_valid (abort).
- mem_rsp_valid arriving outside WAIT is ignored.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_data=0, resp_err=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. The counter is also 0.
- Reset asserted mid-transaction returns to IDLE immediately. The outstanding bus response is dropped.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Best-case latency, cycles after accept edge T:
  - mem_req_valid at T+1.
  - With mem_req_ready at T+1 and mem_rsp_valid at T+2: resp_valid at T+3.
- Fault path: resp_valid at T+1.
- One transaction outstanding max. req_ready=0 from accept until the cycle after the resp handshake.
- Back-to-back throughput: one op per 4 cycles minimum.
- mem_rsp_valid in the same cycle as the mem_req_ready handshake is ignored (state is REQ). The bus must respond ≥1 cycle after accept.

## Test plan
- XLEN=32, SW addr 0x80000004 wdata 0xDEADBEEF, bus ready immediately → mem_addr 0x80000004, wstrb 4'hF, resp err 00 at T+3.
- SH addr 0x...02 wdata 0x1234 → mem_wdata 0x12340000, wstrb 4'hC. SB addr 0x...03 wdata 0xAB → mem_wdata 0xAB000000, wstrb 4'h8.
- Bus word 0x80FF7F01:
  - LB o=3 → 0xFFFFFF80.
  - LBU o=3 → 0x00000080.
  - LH o=2 → 0xFFFF80FF.
  - LHU o=0 → 0x00007F01.
- LW addr 0x...02 → err 01 at T+1, no mem_req_valid. Op 0011 at XLEN=32 → err 01.
- mem_req_ready held low 3 cycles → payload stable throughout. Then mem_rsp_err=1 → err 10, data 0. resp_ready low 2 cycles → resp held.
- TIMEOUT=8, no response → err 11 exactly 8 cycles after accept. A later stray mem_rsp_valid is ignored. XLEN=64 LWU of 0xFFFFFFFF → 0x00000000FFFFFFFF.

Source files
------------

// File: rtl/ysyx_25020047_lsu_pipe.sv
// ysyx_25020047_lsu_pipe: handshaked load/store unit sitting between EXU and WBU.
// Each accepted request issues at most one transaction on the memory bus.
// Stores get byte strobes. Loads are extracted from the aligned bus word and
// sign- or zero-extended according to funct3. Faults come back as error codes.
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_req_*, o_req_ready             EXU request {is_store, funct3}, addr, wdata
//   o_resp_*, i_resp_ready           WBU result: data plus error code
//                                    (00 ok, 01 addr/op fault, 10 bus error, 11 timeout)
//   o_mem_req_*, i_mem_req_ready     bus request: we, aligned addr, lane data, strobes
//   i_mem_rsp_*                      bus response; always accepted, ignored outside WAIT
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// REQ   | bus request presented, payload held until mem_req_ready
// WAIT  | waiting for the bus response
// RESP  | result presented to WBU until resp_ready
module ysyx_25020047_lsu_pipe #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_op,
  input  logic [31:0]       i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_resp_data,
  output logic [1:0]        o_resp_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rsp_data,
  input  logic              i_mem_rsp_err
);

  localparam int NB = XLEN / 8;
  localparam int OB = (XLEN == 64) ? 3 : 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] E_OK   = 2'b00;
  localparam logic [1:0] E_ADDR = 2'b01;
  localparam logic [1:0] E_BUS  = 2'b10;
  localparam logic [1:0] E_TMO  = 2'b11;

  logic [1:0]    r_state;
  logic [31:0]   r_cnt;
  logic [1:0]    r_sz;
  logic [OB-1:0] r_off;
  logic          r_sign;
  logic          r_store;

  logic            w_store;
  logic [2:0]      w_f3;
  logic [1:0]      w_sz;
  logic            w_legal;
  logic            w_mis;
  logic [OB-1:0]   w_off;
  logic [NB-1:0]   w_mask;
  logic [NB-1:0]   w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_load;
  logic            w_tmo;

  assign w_store = i_req_op[3];
  assign w_f3    = i_req_op[2:0];
  assign w_sz    = w_f3[1:0];
  assign w_off   = i_req_addr[OB-1:0];

  always_comb begin
    w_legal = 1'b0;
    if (w_store) begin
      case (w_f3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (w_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_mis  = 1'b0;
    w_mask = '0;
    case (w_sz)
      2'd0: begin w_mis = 1'b0;               w_mask = NB'(8'h01); end
      2'd1: begin w_mis = i_req_addr[0];      w_mask = NB'(8'h03); end
      2'd2: begin w_mis = |i_req_addr[1:0];   w_mask = NB'(8'h0F); end
      default: begin w_mis = |i_req_addr[2:0]; w_mask = NB'(8'hFF); end
    endcase
  end

  assign w_wstrb = w_mask << w_off;
  assign w_wdata = i_req_wdata << {w_off, 3'b000};

  // Load extraction works on the registered offset/size; the bus word is only
  // consumed on the WAIT->RESP edge, so resp_data stays registered.
  assign w_sh = i_mem_rsp_data >> {r_off, 3'b000};

  always_comb begin
    w_load = w_sh;
    case (r_sz)
      2'd0: begin
        if (r_sign) w_load = XLEN'($signed(w_sh[7:0]));
        else        w_load = XLEN'(w_sh[7:0]);
      end
      2'd1: begin
        if (r_sign) w_load = XLEN'($signed(w_sh[15:0]));
        else        w_load = XLEN'(w_sh[15:0]);
      end
      2'd2: begin
        if (r_sign) w_load = XLEN'($signed(w_sh[31:0]));
        else        w_load = XLEN'(w_sh[31:0]);
      end
      default: w_load = w_sh;
    endcase
  end

  assign w_tmo = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

  assign o_req_ready     = (r_state == S_IDLE);
  assign o_mem_req_valid = (r_state == S_REQ);
  assign o_resp_valid    = (r_state == S_RESP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sz        <= '0;
      r_off       <= '0;
      r_sign      <= 1'b0;
      r_store     <= 1'b0;
      o_resp_data <= '0;
      o_resp_err  <= E_OK;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_cnt   <= '0;
            r_sz    <= w_sz;
            r_off   <= w_off;
            r_sign  <= ~w_f3[2];
            r_store <= w_store;
            if (w_legal && !w_mis) begin
              r_state     <= S_REQ;
              o_mem_we    <= w_store;
              o_mem_addr  <= {i_req_addr[31:OB], OB'(0)};
              o_mem_wdata <= w_wdata;
              o_mem_wstrb <= w_store ? w_wstrb : '0;
            end else begin
              r_state     <= S_RESP;
              o_resp_data <= '0;
              o_resp_err  <= E_ADDR;
              o_mem_we    <= 1'b0;
              o_mem_wstrb <= '0;
            end
          end
        end
        S_REQ: begin
          if (w_tmo) begin
            r_state     <= S_RESP;
            o_resp_data <= '0;
            o_resp_err  <= E_TMO;
            o_mem_we    <= 1'b0;
            o_mem_wstrb <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if (i_mem_req_ready) begin
              r_state     <= S_WAIT;
              o_mem_we    <= 1'b0;
              o_mem_wstrb <= '0;
            end
          end
        end
        S_WAIT: begin
          if (w_tmo) begin
            r_state     <= S_RESP;
            o_resp_data <= '0;
            o_resp_err  <= E_TMO;
          end else begin
            r_cnt <= r_cnt + 32'd1;
            if (i_mem_rsp_valid) begin
              r_state <= S_RESP;
              if (i_mem_rsp_err) begin
                o_resp_data <= '0;
                o_resp_err  <= E_BUS;
              end else begin
                o_resp_data <= r_store ? '0 : w_load;
                o_resp_err  <= E_OK;
              end
            end
          end
        end
        default: begin
          if (i_resp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu_pipe.sv
module tb_ysyx_25020047_lsu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 32-bit instance, short timeout
  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [3:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_data;
  logic [1:0]  a_resp_err;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rsp_data;
  logic [3:0]  a_mem_wstrb;
  logic        a_mem_rsp_valid, a_mem_rsp_err;

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [3:0]  b_req_op;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata, b_resp_data;
  logic [1:0]  b_resp_err;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_we;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata, b_mem_rsp_data;
  logic [7:0]  b_mem_wstrb;
  logic        b_mem_rsp_valid, b_mem_rsp_err;

  ysyx_25020047_lsu_pipe #(.XLEN(32), .TIMEOUT(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_op(a_req_op),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
    .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
    .o_resp_data(a_resp_data), .o_resp_err(a_resp_err),
    .o_mem_req_valid(a_mem_req_valid), .i_mem_req_ready(a_mem_req_ready),
    .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .o_mem_wstrb(a_mem_wstrb), .i_mem_rsp_valid(a_mem_rsp_valid),
    .i_mem_rsp_data(a_mem_rsp_data), .i_mem_rsp_err(a_mem_rsp_err)
  );

  ysyx_25020047_lsu_pipe #(.XLEN(64), .TIMEOUT(8)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_op(b_req_op),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
    .o_resp_data(b_resp_data), .o_resp_err(b_resp_err),
    .o_mem_req_valid(b_mem_req_valid), .i_mem_req_ready(b_mem_req_ready),
    .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_wstrb(b_mem_wstrb), .i_mem_rsp_valid(b_mem_rsp_valid),
    .i_mem_rsp_data(b_mem_rsp_data), .i_mem_rsp_err(b_mem_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the 32-bit unit with the bus ready at once and the
  // response one cycle later.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rsp, input logic rerr,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_strb, input logic [31:0] e_data,
                       input logic [1:0] e_err);
    check({tag, ".rdy"}, a_req_ready, 1);
    a_req_valid = 1; a_req_op = op; a_req_addr = addr; a_req_wdata = wdata;
    a_mem_req_ready = 1;
    tick();
    a_req_valid = 0;
    check({tag, ".mvalid"}, a_mem_req_valid, 1);
    check({tag, ".maddr"}, a_mem_addr, e_addr);
    check({tag, ".mwdata"}, a_mem_wdata, e_wdata);
    check({tag, ".wstrb"}, a_mem_wstrb, e_strb);
    check({tag, ".we"}, a_mem_we, op[3]);
    check({tag, ".busy"}, a_req_ready, 0);
    tick();
    a_mem_req_ready = 0;
    check({tag, ".mdone"}, a_mem_req_valid, 0);
    a_mem_rsp_valid = 1; a_mem_rsp_data = rsp; a_mem_rsp_err = rerr;
    tick();
    a_mem_rsp_valid = 0; a_mem_rsp_err = 0;
    check({tag, ".rvalid"}, a_resp_valid, 1);
    check({tag, ".rdata"}, a_resp_data, e_data);
    check({tag, ".rerr"}, a_resp_err, e_err);
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    check({tag, ".rdone"}, a_resp_valid, 0);
  endtask

  task automatic do_fault(input string tag, input logic [3:0] op, input logic [31:0] addr);
    a_req_valid = 1; a_req_op = op; a_req_addr = addr; a_req_wdata = 32'hFFFFFFFF;
    tick();
    a_req_valid = 0;
    check({tag, ".rvalid"}, a_resp_valid, 1);
    check({tag, ".rerr"}, a_resp_err, 2'b01);
    check({tag, ".rdata"}, a_resp_data, 0);
    check({tag, ".mvalid"}, a_mem_req_valid, 0);
    check({tag, ".wstrb"}, a_mem_wstrb, 0);
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    check({tag, ".rdy"}, a_req_ready, 1);
  endtask

  task automatic do64(input string tag, input logic [3:0] op, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic [63:0] rsp,
                      input logic [31:0] e_addr, input logic [63:0] e_wdata,
                      input logic [7:0] e_strb, input logic [63:0] e_data);
    b_req_valid = 1; b_req_op = op; b_req_addr = addr; b_req_wdata = wdata;
    b_mem_req_ready = 1;
    tick();
    b_req_valid = 0;
    check({tag, ".maddr"}, b_mem_addr, e_addr);
    check({tag, ".mwdata"}, b_mem_wdata, e_wdata);
    check({tag, ".wstrb"}, b_mem_wstrb, e_strb);
    tick();
    b_mem_req_ready = 0;
    b_mem_rsp_valid = 1; b_mem_rsp_data = rsp;
    tick();
    b_mem_rsp_valid = 0;
    check({tag, ".rvalid"}, b_resp_valid, 1);
    check({tag, ".rdata"}, b_resp_data, e_data);
    check({tag, ".rerr"}, b_resp_err, 0);
    b_resp_ready = 1;
    tick();
    b_resp_ready = 0;
  endtask

  initial begin
    a_req_valid = 0; a_req_op = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
    a_mem_req_ready = 0; a_mem_rsp_valid = 0; a_mem_rsp_data = 0; a_mem_rsp_err = 0;
    b_req_valid = 0; b_req_op = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;
    b_mem_req_ready = 0; b_mem_rsp_valid = 0; b_mem_rsp_data = 0; b_mem_rsp_err = 0;
    rst_n = 0;
    tick();
    tick();
    check("rst.req_ready", a_req_ready, 1);
    check("rst.resp_valid", a_resp_valid, 0);
    check("rst.resp_data", a_resp_data, 0);
    check("rst.resp_err", a_resp_err, 0);
    check("rst.mem_req_valid", a_mem_req_valid, 0);
    check("rst.mem_we", a_mem_we, 0);
    check("rst.mem_addr", a_mem_addr, 0);
    check("rst.mem_wdata", a_mem_wdata, 0);
    check("rst.mem_wstrb", a_mem_wstrb, 0);
    check("rst64.req_ready", b_req_ready, 1);
    rst_n = 1;
    tick();

    // stores
    do_op("sw", 4'b1010, 32'h80000004, 32'hDEADBEEF, 32'h55555555, 0,
          32'h80000004, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    do_op("sh", 4'b1001, 32'h80000002, 32'h00001234, 32'h55555555, 0,
          32'h80000000, 32'h12340000, 4'hC, 32'h0, 2'b00);
    do_op("sb", 4'b1000, 32'h80000003, 32'h000000AB, 32'h55555555, 0,
          32'h80000000, 32'hAB000000, 4'h8, 32'h0, 2'b00);
    // loads from bus word 0x80FF7F01
    do_op("lb", 4'b0000, 32'h80000013, 32'h0, 32'h80FF7F01, 0,
          32'h80000010, 32'h0, 4'h0, 32'hFFFFFF80, 2'b00);
    do_op("lbu", 4'b0100, 32'h80000013, 32'h0, 32'h80FF7F01, 0,
          32'h80000010, 32'h0, 4'h0, 32'h00000080, 2'b00);
    do_op("lh", 4'b0001, 32'h80000002, 32'h0, 32'h80FF7F01, 0,
          32'h80000000, 32'h0, 4'h0, 32'hFFFF80FF, 2'b00);
    do_op("lhu", 4'b0101, 32'h80000000, 32'h0, 32'h80FF7F01, 0,
          32'h80000000, 32'h0, 4'h0, 32'h00007F01, 2'b00);
    do_op("lw", 4'b0010, 32'h80000008, 32'h0, 32'h80FF7F01, 0,
          32'h80000008, 32'h0, 4'h0, 32'h80FF7F01, 2'b00);
    do_op("lw_buserr", 4'b0010, 32'h8000000C, 32'h0, 32'h12345678, 1,
          32'h8000000C, 32'h0, 4'h0, 32'h0, 2'b10);

    // faults
    do_fault("lw_mis", 4'b0010, 32'h80000002);
    do_fault("op0011", 4'b0011, 32'h80000000);
    do_fault("sh_mis", 4'b1001, 32'h80000001);
    do_fault("sd32", 4'b1011, 32'h80000000);

    // bus stalls request for 3 cycles, then bus error, then WBU stalls 2 cycles
    a_req_valid = 1; a_req_op = 4'b1010; a_req_addr = 32'h80000040; a_req_wdata = 32'hCAFEF00D;
    a_mem_req_ready = 0;
    tick();
    a_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("stall.mvalid", a_mem_req_valid, 1);
      check("stall.maddr", a_mem_addr, 32'h80000040);
      check("stall.mwdata", a_mem_wdata, 32'hCAFEF00D);
      check("stall.wstrb", a_mem_wstrb, 4'hF);
      tick();
    end
    a_mem_req_ready = 1;
    check("stall.mvalid4", a_mem_req_valid, 1);
    tick();
    a_mem_req_ready = 0;
    check("stall.mdone", a_mem_req_valid, 0);
    a_mem_rsp_valid = 1; a_mem_rsp_err = 1; a_mem_rsp_data = 32'h12345678;
    tick();
    a_mem_rsp_valid = 0; a_mem_rsp_err = 0;
    for (int i = 0; i < 3; i++) begin
      check("berr.rvalid", a_resp_valid, 1);
      check("berr.rerr", a_resp_err, 2'b10);
      check("berr.rdata", a_resp_data, 0);
      if (i < 2) tick();
    end
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    check("berr.rdone", a_resp_valid, 0);

    // timeout while waiting for a response
    a_req_valid = 1; a_req_op = 4'b0010; a_req_addr = 32'h80000050; a_mem_req_ready = 1;
    tick();
    a_req_valid = 0;
    tick();
    a_mem_req_ready = 0;
    repeat (6) tick();
    check("tmo.early", a_resp_valid, 0);
    tick();
    check("tmo.rvalid", a_resp_valid, 1);
    check("tmo.rerr", a_resp_err, 2'b11);
    check("tmo.rdata", a_resp_data, 0);
    a_mem_rsp_valid = 1; a_mem_rsp_data = 32'hFFFFFFFF;
    tick();
    a_mem_rsp_valid = 0;
    check("stray.rerr", a_resp_err, 2'b11);
    check("stray.rdata", a_resp_data, 0);
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
    a_mem_rsp_valid = 1; a_mem_rsp_err = 1;
    tick();
    a_mem_rsp_valid = 0; a_mem_rsp_err = 0;
    check("stray.idle_rvalid", a_resp_valid, 0);
    do_op("post_stray", 4'b0101, 32'h80000002, 32'h0, 32'hA5A5C3C3, 0,
          32'h80000000, 32'h0, 4'h0, 32'h0000A5A5, 2'b00);

    // timeout while the request is never accepted: abort
    a_req_valid = 1; a_req_op = 4'b1010; a_req_addr = 32'h80000060; a_req_wdata = 32'h11111111;
    a_mem_req_ready = 0;
    tick();
    a_req_valid = 0;
    repeat (7) tick();
    check("abort.mvalid_pre", a_mem_req_valid, 1);
    tick();
    check("abort.mvalid", a_mem_req_valid, 0);
    check("abort.wstrb", a_mem_wstrb, 0);
    check("abort.rvalid", a_resp_valid, 1);
    check("abort.rerr", a_resp_err, 2'b11);
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;

    // reset in the middle of a transaction
    a_req_valid = 1; a_req_op = 4'b0010; a_req_addr = 32'h80000070; a_mem_req_ready = 0;
    tick();
    a_req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    check("midrst.mvalid", a_mem_req_valid, 0);
    check("midrst.rdy", a_req_ready, 1);
    tick();
    rst_n = 1;
    tick();
    do_op("post_rst", 4'b0000, 32'h80000001, 32'h0, 32'h00007F00, 0,
          32'h80000000, 32'h0, 4'h0, 32'h0000007F, 2'b00);

    // 64-bit unit
    do64("lwu64", 4'b0110, 32'h80000004, 64'h0, 64'hFFFFFFFF_00000000,
         32'h80000000, 64'h0, 8'h00, 64'h00000000_FFFFFFFF);
    do64("lw64", 4'b0010, 32'h80000004, 64'h0, 64'hFFFFFFFF_00000000,
         32'h80000000, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFFFFF);
    do64("ld64", 4'b0011, 32'h80000008, 64'h0, 64'h80000000_00000001,
         32'h80000008, 64'h0, 8'h00, 64'h80000000_00000001);
    do64("sw64", 4'b1010, 32'h80000004, 64'h11223344, 64'h0,
         32'h80000000, 64'h11223344_00000000, 8'hF0, 64'h0);
    do64("sd64", 4'b1011, 32'h80000008, 64'h01020304_05060708, 64'h0,
         32'h80000008, 64'h01020304_05060708, 8'hFF, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
